// File: rtl/mux_2x1_pkg.sv
// Shared defaults for the 2-to-1 multiplexer block and its transition counter.
package mux_2x1_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;

endpackage : mux_2x1_pkg

// File: rtl/mux_2x1_sat_counter.sv
// Saturating up-counter: advances by one on each clock edge where INC is high,
// and holds at its all-ones value rather than wrapping.
module mux_2x1_sat_counter #(
    parameter int CNT_W = mux_2x1_pkg::DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INC,
    output logic [CNT_W-1:0] COUNT
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             at_max;

    assign at_max = &count_q;

    always_comb begin
        count_d = count_q;
        if (INC && !at_max) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign COUNT = count_q;

endmodule : mux_2x1_sat_counter

// File: rtl/mux_2x1.sv
// 2-to-1 data multiplexer with a combinational output, a registered copy of the
// selected data, and a saturating count of sampled select transitions.
module mux_2x1
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SEL,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Y_Q,
    output logic [CNT_W-1:0] SEL_CNT
);

    logic [WIDTH-1:0] y_mux;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] y_d;
    logic             sel_q;
    logic             sel_d;
    logic             sel_toggle;

    assign y_mux = SEL ? B : A;
    assign Y     = y_mux;

    assign y_d   = y_mux;
    assign sel_d = SEL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            y_q   <= '0;
            sel_q <= 1'b0;
        end else begin
            y_q   <= y_d;
            sel_q <= sel_d;
        end
    end

    assign Y_Q = y_q;

    // Only edge-sampled changes of SEL count; sub-cycle glitches are invisible here.
    assign sel_toggle = SEL ^ sel_q;

    mux_2x1_sat_counter #(
        .CNT_W (CNT_W)
    ) u_sel_counter (
        .CLK   (CLK),
        .RST   (RST),
        .INC   (sel_toggle),
        .COUNT (SEL_CNT)
    );

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1: directed scenarios plus a randomized run
// compared against a behavioural model of the selection and transition-count rules.
module tb_mux_2x1;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 2;
    localparam int MAX_L   = (1 << CNT_W) - 1;
    localparam int MAX_S   = (1 << CNT_W_S) - 1;

    logic               clk;
    logic               rst;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sel;
    logic [WIDTH-1:0]   y;
    logic [WIDTH-1:0]   y_q;
    logic [CNT_W-1:0]   sel_cnt;
    logic [WIDTH-1:0]   y_s;
    logic [WIDTH-1:0]   y_q_s;
    logic [CNT_W_S-1:0] sel_cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_yq    = 0;
    int m_prev  = 0;
    int m_cnt   = 0;
    int m_cnt_s = 0;

    mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .CLK(clk), .RST(rst), .A(a), .B(b), .SEL(sel),
        .Y(y), .Y_Q(y_q), .SEL_CNT(sel_cnt)
    );

    mux_2x1 #(.WIDTH(WIDTH), .CNT_W(CNT_W_S)) dut_sat (
        .CLK(clk), .RST(rst), .A(a), .B(b), .SEL(sel),
        .Y(y_s), .Y_Q(y_q_s), .SEL_CNT(sel_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: registered copy of the selected word and a count of edge-to-edge SEL changes.
    always @(posedge clk) begin
        if (rst) begin
            m_yq    <= 0;
            m_prev  <= 0;
            m_cnt   <= 0;
            m_cnt_s <= 0;
        end else begin
            m_yq   <= sel ? int'(b) : int'(a);
            m_prev <= int'(sel);
            if (int'(sel) != m_prev) begin
                m_cnt   <= (m_cnt   < MAX_L) ? m_cnt + 1   : m_cnt;
                m_cnt_s <= (m_cnt_s < MAX_S) ? m_cnt_s + 1 : m_cnt_s;
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; a = 8'h55; b = 8'hAA; sel = 1'b0;
        @(negedge clk);
        checks++;
        if (y_q !== 8'h00) begin
            errors++; $display("FAIL reset_yq got %h want 00", y_q);
        end
        checks++;
        if (sel_cnt !== 16'd0 || sel_cnt_s !== 2'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", sel_cnt, sel_cnt_s);
        end
        $display("reset: Y_Q=%h SEL_CNT=%0d", y_q, sel_cnt);
    endtask

    task automatic test_comb();
        // Starts at t=10 (a negedge); moves to t=11 to change SEL.
        a = 8'h55; b = 8'hAA; sel = 1'b0;
        #1;
        checks++;
        if (y !== 8'h55) begin errors++; $display("FAIL comb_sel0 got %h want 55", y); end
        sel = 1'b1;
        #1;
        checks++;
        if (y !== 8'hAA) begin errors++; $display("FAIL comb_sel1 got %h want aa", y); end
        sel = 1'b0;
        #1;
        checks++;
        if (y !== 8'h55) begin errors++; $display("FAIL comb_back got %h want 55", y); end
        $display("comb: Y follows SEL with A=55 B=aa, last Y=%h", y);
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        a = 8'h55; b = 8'hAA; sel = 1'b1; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (y_q !== 8'h00 || y !== 8'hAA) begin
                errors++; $display("FAIL rst_hold%0d got Y_Q=%h Y=%h want 00/aa", i, y_q, y);
            end
        end
        rst = 1'b0;
        #1;
        checks++;
        if (y !== 8'hAA) begin errors++; $display("FAIL rst_release_y got %h want aa", y); end
        @(negedge clk);
        checks++;
        if (y_q !== 8'hAA) begin errors++; $display("FAIL rst_release_yq got %h want aa", y_q); end
        checks++;
        if (sel_cnt !== 16'd1) begin
            errors++; $display("FAIL first_sel1_counts got %0d want 1", sel_cnt);
        end
        $display("reset priority: Y_Q=%h SEL_CNT=%0d after release", y_q, sel_cnt);
    endtask

    task automatic test_count();
        rst = 1'b1; sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = ~sel;
            @(negedge clk);
        end
        checks++;
        if (sel_cnt !== 16'd5) begin errors++; $display("FAIL count_5 got %0d want 5", sel_cnt); end
        for (int i = 0; i < 3; i++) @(negedge clk);
        checks++;
        if (sel_cnt !== 16'd5) begin errors++; $display("FAIL count_hold got %0d want 5", sel_cnt); end
        $display("count: SEL_CNT=%0d after 5 toggles + 3 holds", sel_cnt);
    endtask

    task automatic test_saturation();
        rst = 1'b1; sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sel = ~sel;
            @(negedge clk);
            checks++;
            if (int'(sel_cnt_s) != ((i + 1 < MAX_S) ? i + 1 : MAX_S)) begin
                errors++; $display("FAIL sat_step%0d got %0d want %0d", i, sel_cnt_s,
                                   (i + 1 < MAX_S) ? i + 1 : MAX_S);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (sel_cnt_s !== 2'd0) begin errors++; $display("FAIL sat_reset got %0d want 0", sel_cnt_s); end
        rst = 1'b0;
        $display("saturation: narrow counter cleared to %0d by reset", sel_cnt_s);
    endtask

    task automatic test_between_edges();
        logic [CNT_W-1:0] cnt_before;
        sel = 1'b0; a = 8'h55;
        @(negedge clk);
        @(negedge clk);
        cnt_before = sel_cnt;
        a = 8'h0F;
        #1;
        checks++;
        if (y !== 8'h0F) begin errors++; $display("FAIL mid_y got %h want 0f", y); end
        checks++;
        if (y_q !== 8'h55) begin errors++; $display("FAIL mid_yq_early got %h want 55", y_q); end
        sel = 1'b1; #1; sel = 1'b0;  // glitch well inside one period
        @(negedge clk);
        checks++;
        if (y_q !== 8'h0F) begin errors++; $display("FAIL mid_yq_edge got %h want 0f", y_q); end
        checks++;
        if (sel_cnt !== cnt_before) begin
            errors++; $display("FAIL glitch_not_counted got %0d want %0d", sel_cnt, cnt_before);
        end
        $display("between edges: Y=%h Y_Q=%h SEL_CNT=%0d", y, y_q, sel_cnt);
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            sel = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 31) == 0);
            #1;
            checks++;
            if (int'(y) != (sel ? int'(b) : int'(a))) begin
                errors++; bad++;
                $display("FAIL rand_y[%0d] got %h want %h", i, y, sel ? b : a);
            end
            @(negedge clk);
            checks++;
            if (int'(y_q) != m_yq || int'(sel_cnt) != m_cnt || int'(sel_cnt_s) != m_cnt_s
                || y_q_s !== y_q) begin
                errors++; bad++;
                $display("FAIL rand_seq[%0d] got Y_Q=%h CNT=%0d CNTS=%0d want %h %0d %0d",
                         i, y_q, sel_cnt, sel_cnt_s, m_yq[WIDTH-1:0], m_cnt, m_cnt_s);
            end
        end
        rst = 1'b0;
        $display("random: 300 cycles, final SEL_CNT=%0d, %0d mismatches", sel_cnt, bad);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; sel = 1'b0;
        test_reset();
        test_comb();
        test_reset_priority();
        test_count();
        test_saturation();
        test_between_edges();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_2x1

// File: doc/mux_2x1.md
Name: mux_2x1

Overview:
- Parameterised 2-to-1 data multiplexer.
- Combinational output Y follows SEL: SEL=0 selects A, SEL=1 selects B. No clock is involved.
- Also provides a registered copy of the selected data and a saturating count of select transitions, both on a single clock domain.
- Used wherever a datapath chooses between two equal-width sources, with the registered outputs feeding downstream pipelines and debug/status logic.

Parameters:
- WIDTH, 8, data width of A, B, Y and Y_Q.
- CNT_W, 16, width of the select-transition counter SEL_CNT.

Ports:
- CLK  input  1  rising-edge clock for all registered outputs.
- RST  input  1  synchronous, active-high reset.
- A  input  WIDTH  data input 0, selected when SEL=0.
- B  input  WIDTH  data input 1, selected when SEL=1.
- SEL  input  1  select line.
- Y  output  WIDTH  combinational mux output.
- Y_Q  output  WIDTH  registered mux output.
- SEL_CNT  output  CNT_W  number of sampled SEL transitions, saturating.

Behaviour:
- Y = SEL ? B : A, purely combinational.
  - Zero clock latency; settles within the same delta/propagation window as an input change.
  - Y is independent of CLK and RST.
  - Y must be valid 1 ns after any A, B or SEL change in zero-delay simulation.
- Y_Q:
  - On each rising CLK edge, Y_Q <= (SEL ? B : A).
  - Latency is 1 cycle.
  - When RST=1 at an edge, Y_Q <= 0. RST takes priority over data capture.
- SEL_Q (internal):
  - Holds SEL sampled at the previous rising edge.
  - Reset value is 0.
- SEL_CNT:
  - At each rising edge with RST=0, if SEL != SEL_Q, SEL_CNT increments by 1.
  - Saturates at 2^CNT_W-1; it never wraps.
  - Reset value is 0.
  - Toggles shorter than one clock period between edges are not counted.
- Reset mid-operation:
  - Y_Q, SEL_Q and SEL_CNT clear on the reset edge.
  - After reset is released, a first sampled SEL=1 counts as a transition, because SEL_Q resets to 0.
- An X/Z value on SEL gives no defined requirement for Y. Y_Q and SEL_CNT must not be left X after a reset edge.
- No handshake and no state machine.

Decomposition:
- No shared package required.
- WIDTH and CNT_W are local parameters of the block.
- One natural sub-module: mux_2x1_sat_counter.
  - Ports: CLK, RST, INC, COUNT, parameterised by CNT_W.
  - Holds the saturating transition counter.
  - Instantiated once, with INC = SEL ^ SEL_Q.
- The mux and output register stay in the top module.

Test Plan:
- A=0x55, B=0xAA, SEL=0, wait 1 ns -> Y=0x55.
- Then SEL=1 at t=11 ns, wait 1 ns -> Y=0xAA. Then SEL=0 -> Y returns to 0x55 within 1 ns.
- RST=1 for 2 edges, A=0x55, B=0xAA, SEL=1 -> Y_Q=0x00 during reset, Y=0xAA throughout. After RST drops, Y_Q=0xAA one edge later.
- From reset, toggle SEL every clock for 5 edges -> SEL_CNT=5. Hold SEL constant for 3 edges -> SEL_CNT stays 5.
- CNT_W=2, toggle SEL for 6 edges -> SEL_CNT stops at 3 with no wrap. Assert RST -> SEL_CNT=0 on that edge.
- Change A from 0x55 to 0x0F with SEL=0 between clock edges -> Y=0x0F immediately. Y_Q updates to 0x0F only at the next rising edge.
